cpu_register_file_param: RTL and testbench

// Parametrised successor of the CPU register file: NUM_REGS x DATA_W, one write port, two async read ports.

---
 rtl/cpu_register_file_param.sv | 121 ++++++++++++
 tb/tb_cpu_register_file_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_register_file_param.sv
// cpu_register_file_param
// NUM_REGS x DATA_W register file with one write port and two asynchronous
// read ports. It also provides:
//   - optional write-to-read bypass
//   - a saturating loop counter at CNT_IDX
//   - a per-register busy scoreboard for RAM loads that are still in flight
module cpu_register_file_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int ACC_IDX  = 3,
  parameter int CNT_IDX  = 4,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic              cnt_dec,
  input  logic              mark_busy,
  input  logic [AW-1:0]     mark_wa,
  output logic [DATA_W-1:0] rda,
  output logic [DATA_W-1:0] rdb,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DATA_W-1:0] out_acc,
  output logic [DATA_W-1:0] out_count,
  output logic              cnt_zero
);

  // One extra bit, so that NUM_REGS = 2**AW still fits for the range compare.
  localparam logic [AW:0] NR = (AW + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic w_wa_ok;
  logic w_ra_ok;
  logic w_rb_ok;
  logic w_mark_ok;
  logic w_wr_en;
  logic w_byp_a;
  logic w_byp_b;

  // Address range qualification. A write that is out of range is ignored.
  // A read that is out of range returns 0 and reports not busy.
  always_comb begin
    w_ra_ok   = ({1'b0, ra} < NR);
    w_wa_ok   = ({1'b0, wa} < NR);
    w_rb_ok   = ({1'b0, rb} < NR);
    w_mark_ok = ({1'b0, mark_wa} < NR);
    w_wr_en   = we && w_wa_ok;
  end

  // Register array and scoreboard update.
  // NOTE: sequential state uses non-blocking assignments only. This means
  // every branch below sees the pre-edge values of r_regs and r_busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is reset explicitly. Software relies on every
      // register, including the counter, reading 0 after reset. This keeps
      // it out of a plain RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // A write to the counter register takes priority over a decrement
        // on the same edge.
        if (w_wr_en && (wa == AW'(i))) begin
          r_regs[i] <= wd;
        end else if ((i == CNT_IDX) && cnt_dec && (r_regs[i] != '0)) begin
          r_regs[i] <= r_regs[i] - DATA_W'(1);
        end

        // When a new load is issued to a register, it supersedes a writeback
        // to that register on the same edge.
        if (mark_busy && w_mark_ok && (mark_wa == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_en && (wa == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Asynchronous read ports, with the optional same-cycle write forwarding.
  always_comb begin
    w_byp_a = BYPASS && !reset && w_wr_en && (wa == ra);
    w_byp_b = BYPASS && !reset && w_wr_en && (wa == rb);

    rda = '0;
    if (w_byp_a) begin
      rda = wd;
    end else if (w_ra_ok) begin
      rda = r_regs[ra];
    end

    rdb = '0;
    if (w_byp_b) begin
      rdb = wd;
    end else if (w_rb_ok) begin
      rdb = r_regs[rb];
    end
  end

  // Busy flags, accumulator mirror and counter mirror. These come from
  // stored state only; bypass never applies to them.
  always_comb begin
    busy_a    = w_ra_ok && r_busy[ra];
    busy_b    = w_rb_ok && r_busy[rb];
    out_acc   = r_regs[ACC_IDX];
    out_count = r_regs[CNT_IDX];
    cnt_zero  = (r_regs[CNT_IDX] == '0);
  end

endmodule

// File: tb/tb_cpu_register_file_param.sv
// Self-checking bench for cpu_register_file_param.
// It runs directed scenarios first, then randomized traffic. Every output is
// compared against a behavioural model that is held in plain arrays.
module tb_cpu_register_file_param;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int ACC_IDX  = 3;
  localparam int CNT_IDX  = 4;
  localparam bit BYPASS   = 1'b1;
  localparam int AW       = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic [AW-1:0]     ra;
  logic [AW-1:0]     rb;
  logic              cnt_dec;
  logic              mark_busy;
  logic [AW-1:0]     mark_wa;
  logic [DATA_W-1:0] rda;
  logic [DATA_W-1:0] rdb;
  logic              busy_a;
  logic              busy_b;
  logic [DATA_W-1:0] out_acc;
  logic [DATA_W-1:0] out_count;
  logic              cnt_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_regs [NUM_REGS];
  bit m_busy [NUM_REGS];

  cpu_register_file_param #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ACC_IDX  (ACC_IDX),
    .CNT_IDX  (CNT_IDX),
    .BYPASS   (BYPASS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rb        (rb),
    .cnt_dec   (cnt_dec),
    .mark_busy (mark_busy),
    .mark_wa   (mark_wa),
    .rda       (rda),
    .rdb       (rdb),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .out_acc   (out_acc),
    .out_count (out_count),
    .cnt_zero  (cnt_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected read data: forwarded write data when bypass applies, otherwise
  // the stored value, or 0 for an address outside the file.
  function automatic int exp_rd(input int a);
    if (BYPASS && !reset && we && int'(wa) < NUM_REGS && int'(wa) == a) return int'(wd);
    if (a < NUM_REGS) return m_regs[a];
    return 0;
  endfunction

  function automatic int exp_busy(input int a);
    return (a < NUM_REGS) ? int'(m_busy[a]) : 0;
  endfunction

  // Apply the current input settings for one clock cycle. When chk is set,
  // the combinational outputs are compared before the edge. The model is
  // then advanced with the same inputs.
  task automatic cycle(input bit chk);
    #2;
    if (chk) begin
      check("rda",       int'(rda),       exp_rd(int'(ra)));
      check("rdb",       int'(rdb),       exp_rd(int'(rb)));
      check("busy_a",    int'(busy_a),    exp_busy(int'(ra)));
      check("busy_b",    int'(busy_b),    exp_busy(int'(rb)));
      check("out_acc",   int'(out_acc),   m_regs[ACC_IDX]);
      check("out_count", int'(out_count), m_regs[CNT_IDX]);
      check("cnt_zero",  int'(cnt_zero),  int'(m_regs[CNT_IDX] == 0));
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        m_regs[i] = 0;
        m_busy[i] = 1'b0;
      end
    end else begin
      // Decrement first, so that a same-edge write overwrites it.
      if (cnt_dec && m_regs[CNT_IDX] > 0) m_regs[CNT_IDX] = m_regs[CNT_IDX] - 1;
      if (we && int'(wa) < NUM_REGS) begin
        m_regs[wa] = int'(wd);
        m_busy[wa] = 1'b0;
      end
      // Marking a register busy wins over the clear caused by a writeback.
      if (mark_busy && int'(mark_wa) < NUM_REGS) m_busy[mark_wa] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset     = 1'b0;
    we        = 1'b0;
    cnt_dec   = 1'b0;
    mark_busy = 1'b0;
  endtask

  initial begin
    idle();
    wa = '0; wd = '0; ra = '0; rb = '0; mark_wa = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0);

    // Reset test: preload every register with 0xFF and mark every register
    // busy. Then reset while also requesting a write, a decrement and a mark.
    idle();
    for (int i = 0; i < NUM_REGS; i++) begin
      we = 1'b1; wa = AW'(i); wd = 8'hFF; mark_busy = 1'b1; mark_wa = AW'(i);
      cycle(1'b1);
    end
    idle();
    reset = 1'b1; we = 1'b1; wa = 3'd1; wd = 8'h77; cnt_dec = 1'b1;
    mark_busy = 1'b1; mark_wa = 3'd2;
    cycle(1'b0);
    idle();
    ra = 3'd1; rb = 3'd2;
    #1;
    check("rst_rda",      int'(rda),       0);
    check("rst_busy_b",   int'(busy_b),    0);
    check("rst_acc",      int'(out_acc),   0);
    check("rst_cnt_zero", int'(cnt_zero),  1);
    cycle(1'b1);

    // Write and read back, including same-cycle forwarding.
    we = 1'b1; wa = 3'd2; wd = 8'hA5; ra = 3'd2; rb = 3'd0;
    #1;
    check("byp_same_cycle", int'(rda), BYPASS ? 32'hA5 : 0);
    cycle(1'b1);
    idle();
    #1;
    check("wr_next_cycle", int'(rda), 32'hA5);
    cycle(1'b1);

    // Counter: load 3, then decrement four times to 2, 1, 0, 0.
    we = 1'b1; wa = AW'(CNT_IDX); wd = 8'h03;
    cycle(1'b1);
    idle();
    for (int k = 0; k < 4; k++) begin
      cnt_dec = 1'b1;
      cycle(1'b1);
      check("cnt_seq",  int'(out_count), (k < 3) ? 2 - k : 0);
      check("cnt_zero", int'(cnt_zero),   int'(k >= 2));
    end
    idle();

    // Collision: a write to the counter beats a decrement on the same edge.
    we = 1'b1; wa = AW'(CNT_IDX); wd = 8'h05;
    cycle(1'b1);
    we = 1'b1; wa = AW'(CNT_IDX); wd = 8'h10; cnt_dec = 1'b1;
    cycle(1'b1);
    idle();
    check("collision", int'(out_count), 32'h10);

    // Scoreboard behaviour.
    mark_busy = 1'b1; mark_wa = 3'd1; ra = 3'd1;
    cycle(1'b1);
    idle();
    #1;
    check("sb_set", int'(busy_a), 1);
    we = 1'b1; wa = 3'd1; wd = 8'h3C; mark_busy = 1'b1; mark_wa = 3'd1;
    cycle(1'b1);
    idle();
    #1;
    check("sb_set_wins", int'(busy_a), 1);
    we = 1'b1; wa = 3'd1; wd = 8'h4D;
    cycle(1'b1);
    idle();
    #1;
    check("sb_clear", int'(busy_a), 0);

    // Out-of-range addresses: the write is ignored and the reads return 0.
    we = 1'b1; wa = 3'd7; wd = 8'h55; mark_busy = 1'b1; mark_wa = 3'd6;
    ra = 3'd7; rb = 3'd5;
    cycle(1'b1);
    idle();
    #1;
    check("oor_rda",    int'(rda),    0);
    check("oor_busy_a", int'(busy_a), 0);
    for (int i = 0; i < NUM_REGS; i++) begin
      ra = AW'(i); rb = AW'(NUM_REGS - 1 - i);
      cycle(1'b1);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      we        = $urandom_range(0, 1) == 1;
      wa        = ($urandom_range(0, 3) == 0) ? AW'(CNT_IDX) : AW'($urandom_range(0, 7));
      wd        = ($urandom_range(0, 3) == 0) ? 8'h01 : DATA_W'($urandom);
      ra        = AW'($urandom_range(0, 7));
      rb        = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      cnt_dec   = ($urandom_range(0, 2) == 0);
      mark_busy = ($urandom_range(0, 3) == 0);
      mark_wa   = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 7));
      cycle(1'b1);
    end
    idle();
    cycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
